pulse_stretcher: RTL and testbench

//  Output-side counterpart to input debouncing. Turns single-cycle or short

---
 rtl/pulse_stretcher.sv | 139 +++++++++++++
 tb/tb_pulse_stretcher.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns trig_i rising edges into ON-time pulses followed by a forced GAP.
// Define PULSE_STRETCH_QUEUE_EN to queue edges arriving while busy instead of dropping them.
module pulse_stretcher #(
    parameter int unsigned CLK_PERIOD_ns = 20,
    parameter int unsigned ON_TIME_ns    = 100_000_000,
    parameter int unsigned GAP_TIME_ns   = 50_000_000,
    parameter int unsigned QUEUE_DEPTH   = 7,
    localparam int unsigned W            = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         enable,
    input  logic         trig_i,
    output logic         out_o,
    output logic         busy_o,
    output logic         dropped_o,
    output logic [W-1:0] pending_o
);
    localparam int unsigned ON_CYCLES  = ON_TIME_ns / CLK_PERIOD_ns;
    localparam int unsigned GAP_CYCLES = GAP_TIME_ns / CLK_PERIOD_ns;
    localparam int unsigned MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int unsigned TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TW-1:0] ON_RELOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_RELOAD = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ON, GAP} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          trig_prev_q;
    logic          out_q, out_d;
    logic          edge_w;
    logic          late_edge_w;
    logic          drop_w;
    logic          pend_nz_w;
`ifdef PULSE_STRETCH_QUEUE_EN
    logic [W-1:0]  pending_q, pending_d;
`endif

    // trig_prev resets high so a trigger held through reset release is not an event
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            trig_prev_q <= 1'b1;
            out_q       <= 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
            pending_q   <= '0;
`endif
        end else if (enable) begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            trig_prev_q <= trig_i;
            out_q       <= out_d;
`ifdef PULSE_STRETCH_QUEUE_EN
            pending_q   <= pending_d;
`endif
        end
    end

    always_comb begin
        edge_w      = enable & trig_i & ~trig_prev_q;
`ifdef PULSE_STRETCH_QUEUE_EN
        pend_nz_w   = (pending_q != '0);
        pending_d   = pending_q;
`else
        pend_nz_w   = 1'b0;
`endif
        state_d     = state_q;
        timer_d     = timer_q;
        late_edge_w = 1'b0;
        drop_w      = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_w) begin
                    state_d = ON;
                    timer_d = ON_RELOAD;
                end
            end
            ON: begin
                late_edge_w = edge_w;
                if (timer_q == '0) begin
                    state_d = GAP;
                    timer_d = GAP_RELOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    // An edge in the exit cycle is served directly; with pending>0 it nets out
                    if (pend_nz_w || edge_w) begin
                        state_d = ON;
                        timer_d = ON_RELOAD;
                    end else begin
                        state_d = IDLE;
                    end
`ifdef PULSE_STRETCH_QUEUE_EN
                    if (!edge_w && pend_nz_w) begin
                        pending_d = pending_q - 1'b1;
                    end
`endif
                end else begin
                    timer_d     = timer_q - 1'b1;
                    late_edge_w = edge_w;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        if (late_edge_w) begin
`ifdef PULSE_STRETCH_QUEUE_EN
            if (pending_q < W'(QUEUE_DEPTH)) begin
                pending_d = pending_q + 1'b1;
            end else begin
                drop_w = 1'b1;
            end
`else
            drop_w = 1'b1;
`endif
        end
    end

    always_comb begin
        out_d  = (state_d == ON);
        busy_o = (state_q != IDLE) || pend_nz_w;
    end

    assign out_o     = out_q;
    assign dropped_o = drop_w;
`ifdef PULSE_STRETCH_QUEUE_EN
    assign pending_o = pending_q;
`else
    assign pending_o = '0;
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: a pulse-schedule model predicts every output each cycle.
// Honours PULSE_STRETCH_QUEUE_EN in the same way as the design.
module tb_pulse_stretcher;
    localparam int ON    = 5;
    localparam int GAP   = 3;
    localparam int DEPTH = 2;
    localparam int W     = $clog2(DEPTH + 1);

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         enable = 1'b0;
    logic         trig_i = 1'b0;
    logic         out_o, busy_o, dropped_o;
    logic [W-1:0] pending_o;

    always #10 clk = ~clk;

    pulse_stretcher #(
        .CLK_PERIOD_ns(20),
        .ON_TIME_ns   (100),
        .GAP_TIME_ns  (60),
        .QUEUE_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .trig_i   (trig_i),
        .out_o    (out_o),
        .busy_o   (busy_o),
        .dropped_o(dropped_o),
        .pending_o(pending_o)
    );

    // A scheduled pulse: first high cycle s (in enabled-cycle time) and whether it came from the queue
    typedef struct {
        int s;
        bit q;
    } pulse_t;

    typedef struct {
        bit out;
        bit busy;
        int pend;
        bit drop;
        int cyc;
    } exp_t;

    pulse_t sched[$];
    exp_t   expq[$];
    int     ecount    = 0;
    int     last_exit = -1;
    bit     prev      = 1'b1;
    bit     last_adv  = 1'b0;
    int     wall      = 0;
    int     total     = 0;
    int     bad       = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, req);
        end
    endtask

    // One clock interval: drive inputs just after the edge and queue the predicted outputs.
    task automatic cyc(input bit t, input bit en, input bit rn);
        exp_t e;
        int   nq;
        int   s;
        @(posedge clk);
        #1;
        if (last_adv) ecount++;
        wall++;
        trig_i = t;
        enable = en;
        resetn = rn;
        e.cyc  = wall;
        e.out  = 1'b0;
        e.busy = 1'b0;
        e.pend = 0;
        e.drop = 1'b0;
        if (!rn) begin
            sched.delete();
            ecount    = 0;
            last_exit = -1;
            prev      = 1'b1;
            last_adv  = 1'b0;
            expq.push_back(e);
            return;
        end
        while (sched.size() > 0 && sched[0].s + ON + GAP - 1 < ecount) void'(sched.pop_front());
        foreach (sched[i]) begin
            if (ecount >= sched[i].s && ecount <= sched[i].s + ON - 1) e.out = 1'b1;
            if (ecount >= sched[i].s && ecount <= sched[i].s + ON + GAP - 1) e.busy = 1'b1;
            if (sched[i].q && sched[i].s > ecount) begin
                e.pend++;
                e.busy = 1'b1;
            end
        end
        if (en) begin
            if (t && !prev) begin
                if (ecount >= last_exit) begin
                    sched.push_back('{ecount + 1, 1'b0});
                    last_exit = ecount + ON + GAP;
                end else begin
`ifdef PULSE_STRETCH_QUEUE_EN
                    nq = 0;
                    foreach (sched[i]) if (sched[i].q && sched[i].s > ecount + 1) nq++;
                    if (nq < DEPTH) begin
                        s = last_exit + 1;
                        sched.push_back('{s, 1'b1});
                        last_exit = s + ON + GAP - 1;
                    end else begin
                        e.drop = 1'b1;
                    end
`else
                    nq = 0;
                    s  = nq;
                    e.drop = 1'b1;
`endif
                end
            end
            prev = t;
        end
        last_adv = en;
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1);
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("out_o",     e.cyc, 32'(out_o),     32'(e.out));
                chk("busy_o",    e.cyc, 32'(busy_o),    32'(e.busy));
                chk("pending_o", e.cyc, 32'(pending_o), e.pend);
                chk("dropped_o", e.cyc, 32'(dropped_o), 32'(e.drop));
            end
        end
    end

    initial begin
        bit tr;
        bit en;
        bit rn;
        // reset, then a single one-cycle event
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        idle(7);
        cyc(1'b1, 1'b1, 1'b1);
        idle(20);
        // four single-cycle edges in quick succession
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            cyc(1'b0, 1'b1, 1'b1);
        end
        idle(40);
        // edge landing on the final GAP cycle
        cyc(1'b1, 1'b1, 1'b1);
        idle(7);
        cyc(1'b1, 1'b1, 1'b1);
        idle(20);
        // trigger held high across reset release, then reset mid-pulse
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1);
        idle(5);
        cyc(1'b1, 1'b1, 1'b1);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        idle(5);
        // enable dropped for 10 cycles in the middle of ON
        cyc(1'b1, 1'b1, 1'b1);
        idle(2);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1);
        idle(20);
        // second edge two cycles after the first
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        idle(20);
        // randomized traffic with occasional freezes and resets
        tr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) tr = ~tr;
            en = ($urandom_range(0, 9) != 0);
            rn = ($urandom_range(0, 399) != 0);
            cyc(tr, en, rn);
        end
        idle(20);
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain remaining=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
